// File: rtl/icache_refill_if.sv
// Bus bundle for the instruction refill engine: IF-side request/response, the
// byte-wide RAM port with its arbiter handshake, and the i-cache fill write port.
interface icache_refill_if #(
  parameter int ADDR_W = 32
);
  // Handshakes: req/hit/pc describe one fetch per cycle (no ready; IF stalls on busy).
  // mem_req stays high for the whole burst; mem_gnt is held until mem_req drops, and an
  // address on mem_a counts as issued in every cycle where mem_req && mem_gnt.
  // instr_valid and fill_we are single-cycle strobes, stretched only while rdy is low.
  logic              req;
  logic [ADDR_W-1:0] pc;
  logic              hit;
  logic              flush;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_din;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic [31:0]       fill_instr;
  logic              busy;

  modport slave (
    input  req, pc, hit, flush, mem_gnt, mem_din,
    output mem_req, mem_a, instr, instr_valid, fill_we, fill_addr, fill_instr, busy
  );

  modport master (
    output req, pc, hit, flush, mem_gnt, mem_din,
    input  mem_req, mem_a, instr, instr_valid, fill_we, fill_addr, fill_instr, busy
  );
endinterface

// File: rtl/icache_refill.sv
// I-cache miss refill: four little-endian byte reads assembled into one word.
// Optional next-line prefetch after each refill when ICACHE_PREFETCH_EN is defined.
module icache_refill #(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  icache_refill_if.slave bus,
  output logic [2:0]     dbg_state
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_GNT = 3'd1,
    BURST    = 3'd2,
    DONE     = 3'd3,
    PREFETCH = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, addr_q, pc_aligned;
  logic [2:0]        issue_cnt_q, recv_cnt_q;
  logic [31:0]       asm_q, asm_d, instr_q;
  logic              pf_q;
  logic [RAM_LAT-1:0] pipe_v_q;
  logic [1:0]        pipe_k_q [RAM_LAT];

  logic       miss, issue, land, last;
  logic [1:0] land_k;
  logic       start, clear, pf_start, merge;

  assign miss       = bus.req & ~bus.hit;
  assign pc_aligned = bus.pc & ~ADDR_W'(3);

  // The first byte may go out in WAIT_GNT itself, the cycle the grant arrives.
  assign bus.mem_req = (state_q == WAIT_GNT) ||
                       ((state_q == BURST || state_q == PREFETCH) && issue_cnt_q != 3'd4);
  assign issue  = bus.mem_req & bus.mem_gnt;
  assign land   = pipe_v_q[RAM_LAT-1];
  assign land_k = pipe_k_q[RAM_LAT-1];
  assign last   = land && (recv_cnt_q == 3'd3);

  always_comb begin
    asm_d = asm_q;
    if (land) asm_d[{land_k, 3'b000} +: 8] = bus.mem_din;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    clear    = 1'b0;
    pf_start = 1'b0;
    merge    = 1'b0;
    case (state_q)
      IDLE: if (miss && !bus.flush) start = 1'b1;
      WAIT_GNT, BURST: begin
        if (bus.flush)  clear   = 1'b1;
        else if (last)  state_d = DONE;
        else if (issue) state_d = BURST;
      end
      DONE: begin
        state_d = IDLE;
`ifdef ICACHE_PREFETCH_EN
        if (!bus.flush && !miss) pf_start = 1'b1;
`endif
      end
      PREFETCH: begin
        if (bus.flush) clear = 1'b1;
        else if (miss && pc_aligned != base_q) start = 1'b1;
        else begin
          // A demand miss on the word being prefetched just promotes this burst.
          if (miss) merge = 1'b1;
          if (last) state_d = DONE;
        end
      end
      default: clear = 1'b1;
    endcase
    if (start)         state_d = WAIT_GNT;
    else if (clear)    state_d = IDLE;
    else if (pf_start) state_d = PREFETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      issue_cnt_q <= 3'd0;
      recv_cnt_q  <= 3'd0;
      asm_q       <= 32'd0;
      instr_q     <= 32'd0;
      pf_q        <= 1'b0;
      pipe_v_q    <= '0;
      for (int i = 0; i < RAM_LAT; i++) pipe_k_q[i] <= 2'd0;
    end else if (rdy) begin
      state_q <= state_d;
      asm_q   <= asm_d;
      // Any restart drops bytes still in flight so they never reach a lane.
      if (start || clear || pf_start) begin
        issue_cnt_q <= 3'd0;
        recv_cnt_q  <= 3'd0;
        pipe_v_q    <= '0;
      end else begin
        issue_cnt_q <= issue_cnt_q + {2'b00, issue};
        recv_cnt_q  <= recv_cnt_q + {2'b00, land};
        pipe_v_q[0] <= issue;
        pipe_k_q[0] <= issue_cnt_q[1:0];
        for (int i = 1; i < RAM_LAT; i++) begin
          pipe_v_q[i] <= pipe_v_q[i-1];
          pipe_k_q[i] <= pipe_k_q[i-1];
        end
        if (issue && issue_cnt_q != 3'd3) addr_q <= addr_q + ADDR_W'(1);
      end
      if (start) begin
        base_q <= pc_aligned;
        addr_q <= pc_aligned;
        pf_q   <= 1'b0;
      end else if (pf_start) begin
        base_q <= base_q + ADDR_W'(4);
        addr_q <= base_q + ADDR_W'(4);
        pf_q   <= 1'b1;
      end
      if (merge) pf_q <= 1'b0;
      if (state_d == DONE && state_q != DONE) instr_q <= asm_d;
    end
  end

  assign bus.busy        = (state_q == WAIT_GNT) || (state_q == BURST) ||
                           (state_q == PREFETCH && !pf_q);
  assign bus.instr_valid = (state_q == DONE) && !pf_q;
  assign bus.fill_we     = (state_q == DONE);
  assign bus.fill_addr   = base_q;
  assign bus.mem_a       = addr_q;
  assign bus.instr       = instr_q;
  assign bus.fill_instr  = instr_q;
  assign dbg_state       = state_q;
endmodule
